// File: rtl/fft8_frame_ctrl.sv
// Frame scheduler for the 8-point FFT core: collects 8 samples, fires the core, drains bins in order.
// Optional FFT_CTRL_SCALE_EN: output bins are scaled by 1/8 with round-half-up.
module fft8_frame_ctrl #(
  parameter int DW      = 24,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_real,
  input  logic [DW-1:0]   s_imag,
  output logic            fft_en,
  output logic [8*DW-1:0] fft_x_real,
  output logic [8*DW-1:0] fft_x_imag,
  input  logic            fft_valid,
  input  logic [8*DW-1:0] fft_y_real,
  input  logic [8*DW-1:0] fft_y_imag,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_real,
  output logic [DW-1:0]   m_imag,
  output logic [2:0]      m_index,
  output logic            m_last,
  output logic            busy,
  output logic            err_timeout,
  output logic [15:0]     frame_cnt
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FIRE    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    wr_idx_reg, rd_idx_reg;
  logic [7:0]    to_cnt_reg;
  logic          err_reg;
  logic [15:0]   frame_cnt_reg;
  logic [DW-1:0] x_re_reg [8];
  logic [DW-1:0] x_im_reg [8];
  logic [DW-1:0] y_re_reg [8];
  logic [DW-1:0] y_im_reg [8];

  logic s_accept, m_accept, frame_full, drain_done, capture, timeout_hit;
  logic [DW-1:0] bin_re, bin_im;

  assign s_accept   = s_valid && s_ready;
  assign m_accept   = m_valid && m_ready;
  assign frame_full = s_accept && (wr_idx_reg == 3'd7);
  assign drain_done = m_accept && (rd_idx_reg == 3'd7);
  assign capture    = (state_reg == ST_WAIT) && fft_valid;
  // The core gets TIMEOUT full WAIT cycles; a result in the last one is still taken.
  assign timeout_hit = (state_reg == ST_WAIT) && !fft_valid &&
                       (to_cnt_reg == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_COLLECT;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_COLLECT: if (frame_full) state_next = ST_FIRE;
      ST_FIRE:    state_next = ST_WAIT;
      ST_WAIT: begin
        if (fft_valid)        state_next = ST_DRAIN;
        else if (timeout_hit) state_next = ST_COLLECT;
      end
      ST_DRAIN:   if (drain_done) state_next = ST_COLLECT;
      default:    state_next = ST_COLLECT;
    endcase
  end

  always_comb begin
    s_ready = (state_reg == ST_COLLECT);
    fft_en  = (state_reg == ST_FIRE);
    m_valid = (state_reg == ST_DRAIN);
    busy    = (state_reg != ST_COLLECT);
    m_last  = (state_reg == ST_DRAIN) && (rd_idx_reg == 3'd7);
    m_index = rd_idx_reg;
    m_real  = bin_re;
    m_imag  = bin_im;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_reg    <= '0;
      rd_idx_reg    <= '0;
      to_cnt_reg    <= '0;
      err_reg       <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      if (s_accept)                         wr_idx_reg <= wr_idx_reg + 3'd1;
      else if (timeout_hit)                 wr_idx_reg <= '0;
      if (state_reg == ST_FIRE)             to_cnt_reg <= '0;
      else if ((state_reg == ST_WAIT) && !fft_valid) to_cnt_reg <= to_cnt_reg + 8'd1;
      if (timeout_hit)                      err_reg <= 1'b1;
      if (m_accept)                         rd_idx_reg <= rd_idx_reg + 3'd1;
      if (drain_done)                       frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_re_reg[gi] <= '0;
          x_im_reg[gi] <= '0;
          y_re_reg[gi] <= '0;
          y_im_reg[gi] <= '0;
        end else begin
          if (s_accept && (wr_idx_reg == 3'(gi))) begin
            x_re_reg[gi] <= s_real;
            x_im_reg[gi] <= s_imag;
          end
          if (capture) begin
            y_re_reg[gi] <= fft_y_real[gi*DW +: DW];
            y_im_reg[gi] <= fft_y_imag[gi*DW +: DW];
          end
        end
      end
      assign fft_x_real[gi*DW +: DW] = x_re_reg[gi];
      assign fft_x_imag[gi*DW +: DW] = x_im_reg[gi];
    end
  endgenerate

`ifdef FFT_CTRL_SCALE_EN
  // Round-half-up divide by 8, done one bit wider so +4 cannot overflow.
  function automatic logic [DW-1:0] scale8(input logic [DW-1:0] v);
    logic signed [DW:0] ext;
    ext = $signed({v[DW-1], v}) + (DW+1)'(4);
    ext = ext >>> 3;
    return ext[DW-1:0];
  endfunction
  assign bin_re = scale8(y_re_reg[rd_idx_reg]);
  assign bin_im = scale8(y_im_reg[rd_idx_reg]);
`else
  assign bin_re = y_re_reg[rd_idx_reg];
  assign bin_im = y_im_reg[rd_idx_reg];
`endif

  assign err_timeout = err_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Self-checking bench for fft8_frame_ctrl: random frames, a behavioural core model and a beat scoreboard.
module tb_fft8_frame_ctrl;
  localparam int DW      = 24;
  localparam int TIMEOUT = 15;

  logic            clk, rst_n;
  logic            s_valid, s_ready;
  logic [DW-1:0]   s_real, s_imag;
  logic            fft_en;
  logic [8*DW-1:0] fft_x_real, fft_x_imag;
  logic            fft_valid;
  logic [8*DW-1:0] fft_y_real, fft_y_imag;
  logic            m_valid, m_ready;
  logic [DW-1:0]   m_real, m_imag;
  logic [2:0]      m_index;
  logic            m_last, busy, err_timeout;
  logic [15:0]     frame_cnt;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [2:0]    idx;
    logic          last;
  } beat_t;

  int checks = 0;
  int errors = 0;
  beat_t rx_q[$];
  beat_t exp_q[$];
  logic [2*8*DW-1:0] snap_q[$];
  int en_count   = 0;
  int stall_bad  = 0;
  int exp_frames = 0;
  int core_lat   = 3;
  int core_mode  = 0;
  int rdy_mode   = 0;
  bit spur       = 0;
  logic [8*DW-1:0] cy_r, cy_i;

  fft8_frame_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .fft_en(fft_en), .fft_x_real(fft_x_real), .fft_x_imag(fft_x_imag),
    .fft_valid(fft_valid), .fft_y_real(fft_y_real), .fft_y_imag(fft_y_imag),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_index(m_index), .m_last(m_last), .busy(busy),
    .err_timeout(err_timeout), .frame_cnt(frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in FFT core: mode 0 is an arbitrary but fixed mapping of x, mode 1 replays a table.
  function automatic logic [2*8*DW-1:0] core_fn(input logic [8*DW-1:0] xr, input logic [8*DW-1:0] xi);
    logic [8*DW-1:0] yr, yi;
    yr = cy_r;
    yi = cy_i;
    if (core_mode == 0) begin
      for (int k = 0; k < 8; k++) begin
        yr[k*DW +: DW] = xr[(7-k)*DW +: DW] + DW'(k*1000);
        yi[k*DW +: DW] = xi[((k+3)%8)*DW +: DW] - DW'(k);
      end
    end
    return {yi, yr};
  endfunction

  function automatic logic [DW-1:0] exp_bin(input logic [DW-1:0] v);
`ifdef FFT_CTRL_SCALE_EN
    longint t;
    t = longint'($signed(v));
    t = (t + 4) >>> 3;
    return t[DW-1:0];
`else
    return v;
`endif
  endfunction

  initial begin : core_model
    int cd;
    logic [8*DW-1:0] sr, si;
    logic [2*8*DW-1:0] y;
    cd = 0; sr = '0; si = '0;
    fft_valid = 1'b0; fft_y_real = '0; fft_y_imag = '0;
    forever begin
      @(negedge clk);
      fft_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        fft_y_real[i*DW +: DW] = DW'($urandom);
        fft_y_imag[i*DW +: DW] = DW'($urandom);
      end
      if (rst_n !== 1'b1) cd = 0;
      else if (fft_en === 1'b1) begin
        en_count++;
        sr = fft_x_real; si = fft_x_imag;
        snap_q.push_back({si, sr});
        cd = core_lat;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          y = core_fn(sr, si);
          fft_valid = 1'b1;
          fft_y_real = y[8*DW-1:0];
          fft_y_imag = y[2*8*DW-1:8*DW];
        end
      end else if (spur) begin
        spur = 0;
        fft_valid = 1'b1;
      end
    end
  end

  initial begin : ready_drv
    int ph;
    ph = 0;
    m_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1: begin m_ready = (ph % 3 == 0); ph++; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : monitor
    beat_t prev, cur;
    bit pv;
    pv = 0; prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n !== 1'b1) pv = 0;
      else begin
        cur = {m_real, m_imag, m_index, m_last};
        if (pv && (m_valid !== 1'b1 || cur !== prev)) stall_bad++;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
          rx_q.push_back(cur);
          pv = 0;
        end else begin
          pv = (m_valid === 1'b1);
          prev = cur;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic int count_bad();
    int b;
    b = (rx_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) b++;
    return b;
  endfunction

  task automatic push_expected(input logic [8*DW-1:0] xr, input logic [8*DW-1:0] xi);
    logic [2*8*DW-1:0] y;
    beat_t b;
    y = core_fn(xr, xi);
    for (int k = 0; k < 8; k++) begin
      b.re   = exp_bin(y[k*DW +: DW]);
      b.im   = exp_bin(y[8*DW + k*DW +: DW]);
      b.idx  = 3'(k);
      b.last = (k == 7);
      exp_q.push_back(b);
    end
  endtask

  task automatic make_frame(output logic [8*DW-1:0] xr, output logic [8*DW-1:0] xi);
    for (int k = 0; k < 8; k++) begin
      xr[k*DW +: DW] = DW'($urandom);
      xi[k*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic send_sample(input logic [DW-1:0] re, input logic [DW-1:0] im, output bit ok);
    int g;
    bit acc;
    s_valid = 1'b1; s_real = re; s_imag = im; g = 0;
    do begin
      acc = (s_ready === 1'b1);
      @(negedge clk);
      g++;
    end while (!acc && g < 600);
    s_valid = 1'b0;
    ok = acc;
  endtask

  task automatic send_frame(input logic [8*DW-1:0] xr, input logic [8*DW-1:0] xi,
                            input int maxgap, output bit ok);
    bit o;
    ok = 1;
    for (int k = 0; k < 8; k++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      send_sample(xr[k*DW +: DW], xi[k*DW +: DW], o);
      if (!o) ok = 0;
    end
  endtask

  task automatic wait_rx(input int n, output bit ok);
    int g;
    g = 0;
    while (rx_q.size() < n && g < 1000) begin @(negedge clk); g++; end
    ok = (rx_q.size() >= n);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input logic [8*DW-1:0] xr, input logic [8*DW-1:0] xi,
                           input int maxgap, output bit ok);
    bit o1, o2;
    push_expected(xr, xi);
    send_frame(xr, xi, maxgap, o1);
    wait_rx(exp_q.size(), o2);
    exp_frames++;
    ok = o1 && o2;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; s_valid = 1'b0; s_real = '0; s_imag = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, fft_en, m_valid, m_last, busy, err_timeout} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl s_ready/fft_en/m_valid/m_last/busy/err=%b required 100000",
               {s_ready, fft_en, m_valid, m_last, busy, err_timeout});
    end
    checks++;
    if (frame_cnt !== 16'd0 || fft_x_real !== '0 || m_index !== 3'd0) begin
      errors++;
      $display("FAIL reset_regs frame_cnt=%0d m_index=%0d fft_x_nonzero=%0b required 0 0 0",
               frame_cnt, m_index, fft_x_real !== '0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_impulse();
    logic [8*DW-1:0] xr, xi;
    bit ok;
    int e0, n0;
    n0 = rx_q.size();
    spur = 1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rx_q.size() != n0) begin
      errors++;
      $display("FAIL spurious_valid busy=%b beats=%0d required busy=0 beats=%0d", busy, rx_q.size(), n0);
    end
    core_mode = 1; core_lat = 3; rdy_mode = 0;
    cy_r = '0; cy_i = '0;
    for (int k = 0; k < 8; k++) cy_r[k*DW +: DW] = DW'(256);
    xr = '0; xi = '0; xr[0 +: DW] = DW'(256);
    e0 = en_count;
    run_frame(xr, xi, 0, ok);
    checks++;
    if (!ok || en_count - e0 != 1) begin
      errors++;
      $display("FAIL impulse_fire ok=%0b fft_en_pulses=%0d required ok=1 pulses=1", ok, en_count - e0);
    end
    checks++;
    if (snap_q.size() == 0 || snap_q[snap_q.size()-1] !== {xi, xr}) begin
      errors++;
      $display("FAIL impulse_frame_x snapshots=%0d x0_real=%0d required x0_real=256 rest 0",
               snap_q.size(), fft_x_real[0 +: DW]);
    end
    checks++;
    if (count_bad() != 0) begin
      errors++;
      $display("FAIL impulse_beats bad=%0d beats=%0d required bad=0 beats=%0d", count_bad(), rx_q.size(), exp_q.size());
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL impulse_frame_cnt got=%0d required=%0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_dc();
    logic [8*DW-1:0] xr, xi;
    bit ok;
    core_mode = 1; core_lat = 5; rdy_mode = 0;
    cy_r = '0; cy_i = '0; cy_r[0 +: DW] = DW'(2048);
    xi = '0;
    for (int k = 0; k < 8; k++) xr[k*DW +: DW] = DW'(256);
    run_frame(xr, xi, 3, ok);
    checks++;
    if (!ok || count_bad() != 0) begin
      errors++;
      $display("FAIL dc_beats ok=%0b bad=%0d required ok=1 bad=0", ok, count_bad());
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL dc_frame_cnt got=%0d required=%0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_backpressure();
    logic [8*DW-1:0] ar, ai, br, bi;
    bit ok, o, acc;
    int g, sz, s0;
    core_mode = 0; core_lat = 2; rdy_mode = 1; s0 = stall_bad;
    make_frame(ar, ai);
    make_frame(br, bi);
    push_expected(ar, ai);
    send_frame(ar, ai, 1, ok);
    // hold the next frame's first sample during the drain; it may only go in afterwards
    s_valid = 1'b1; s_real = br[0 +: DW]; s_imag = bi[0 +: DW]; g = 0; sz = 0;
    do begin
      acc = (s_ready === 1'b1);
      sz = rx_q.size();
      @(negedge clk);
      g++;
    end while (!acc && g < 600);
    s_valid = 1'b0;
    exp_frames++;
    checks++;
    if (!ok || !acc || sz != exp_q.size()) begin
      errors++;
      $display("FAIL bp_held_sample accepted=%0b beats_at_accept=%0d required accepted=1 beats=%0d",
               acc, sz, exp_q.size());
    end
    checks++;
    if (count_bad() != 0) begin
      errors++;
      $display("FAIL bp_beats_a bad=%0d required=0", count_bad());
    end
    rdy_mode = 2;
    push_expected(br, bi);
    for (int k = 1; k < 8; k++) begin
      send_sample(br[k*DW +: DW], bi[k*DW +: DW], o);
      if (!o) ok = 0;
    end
    wait_rx(exp_q.size(), o);
    exp_frames++;
    checks++;
    if (!ok || !o || count_bad() != 0) begin
      errors++;
      $display("FAIL bp_beats_b ok=%0b bad=%0d required ok=1 bad=0", ok && o, count_bad());
    end
    checks++;
    if (stall_bad != s0) begin
      errors++;
      $display("FAIL bp_stall_stable changes=%0d required=0", stall_bad - s0);
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL bp_frame_cnt got=%0d required=%0d", frame_cnt, exp_frames);
    end
    rdy_mode = 0;
  endtask

  task automatic test_timeout();
    logic [8*DW-1:0] xr, xi;
    bit ok;
    int g, k, n0;
    core_mode = 0; core_lat = 0; rdy_mode = 0;
    n0 = rx_q.size();
    make_frame(xr, xi);
    send_frame(xr, xi, 2, ok);
    g = 0;
    while (fft_en !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    k = 0;
    while (err_timeout !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    // FIRE cycle, then TIMEOUT WAIT cycles, then the flag is visible
    checks++;
    if (!ok || k != TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_cycles ok=%0b cycles_after_fire=%0d required %0d", ok, k, TIMEOUT + 1);
    end
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1 || frame_cnt !== 16'(exp_frames) || rx_q.size() != n0) begin
      errors++;
      $display("FAIL timeout_abort busy=%b s_ready=%b frame_cnt=%0d beats=%0d required 0 1 %0d %0d",
               busy, s_ready, frame_cnt, rx_q.size(), exp_frames, n0);
    end
    core_lat = 2;
    make_frame(xr, xi);
    run_frame(xr, xi, 1, ok);
    checks++;
    if (!ok || count_bad() != 0 || frame_cnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL timeout_recover ok=%0b bad=%0d frame_cnt=%0d required 1 0 %0d",
               ok, count_bad(), frame_cnt, exp_frames);
    end
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky err_timeout=%b required 1", err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    logic [8*DW-1:0] xr, xi;
    bit ok, o;
    int g;
    core_mode = 0; core_lat = 2; rdy_mode = 0;
    make_frame(xr, xi);
    for (int k = 0; k < 5; k++) send_sample(xr[k*DW +: DW], xi[k*DW +: DW], o);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, busy, err_timeout} !== 3'b100 || frame_cnt !== 16'd0 || fft_x_real !== '0) begin
      errors++;
      $display("FAIL rst_collect s_ready/busy/err=%b frame_cnt=%0d x_nonzero=%0b required 100 0 0",
               {s_ready, busy, err_timeout}, frame_cnt, fft_x_real !== '0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete(); exp_q.delete(); exp_frames = 0;
    make_frame(xr, xi);
    send_frame(xr, xi, 0, ok);
    g = 0;
    while (!(m_valid === 1'b1 && m_index === 3'd3) && g < 100) begin @(negedge clk); g++; end
    checks++;
    if (g >= 100) begin
      errors++;
      $display("FAIL rst_drain_reach bin3_seen=0 required 1");
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_last, busy, s_ready, fft_en} !== 5'b00010 || m_index !== 3'd0) begin
      errors++;
      $display("FAIL rst_drain m_valid/m_last/busy/s_ready/fft_en=%b m_index=%0d required 00010 0",
               {m_valid, m_last, busy, s_ready, fft_en}, m_index);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete(); exp_q.delete(); exp_frames = 0;
    rdy_mode = 2;
    make_frame(xr, xi);
    run_frame(xr, xi, 2, ok);
    checks++;
    if (!ok || count_bad() != 0 || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL rst_fresh_frame ok=%0b bad=%0d frame_cnt=%0d required 1 0 1", ok, count_bad(), frame_cnt);
    end
    rdy_mode = 0;
  endtask

  task automatic test_back_to_back();
    logic [8*DW-1:0] xr[3], xi[3];
    bit ok, o;
    int e0, n0;
    core_mode = 0; core_lat = int'($urandom_range(1, 4)); rdy_mode = 0;
    e0 = en_count; n0 = exp_q.size();
    for (int f = 0; f < 3; f++) begin
      make_frame(xr[f], xi[f]);
      push_expected(xr[f], xi[f]);
    end
    ok = 1;
    for (int f = 0; f < 3; f++) begin
      send_frame(xr[f], xi[f], 0, o);
      if (!o) ok = 0;
    end
    wait_rx(exp_q.size(), o);
    exp_frames += 3;
    checks++;
    if (!ok || !o || en_count - e0 != 3 || exp_q.size() - n0 != 24) begin
      errors++;
      $display("FAIL b2b_fire ok=%0b fft_en_pulses=%0d required ok=1 pulses=3", ok && o, en_count - e0);
    end
    checks++;
    if (count_bad() != 0) begin
      errors++;
      $display("FAIL b2b_beats bad=%0d beats=%0d required bad=0 beats=%0d", count_bad(), rx_q.size(), exp_q.size());
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL b2b_frame_cnt got=%0d required=%0d", frame_cnt, exp_frames);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
